fetch_queue: RTL and testbench

- Instruction fetch stage directly upstream of the conveyor.
- Drives the fetch PC to instruction memory and buffers returned 88-bit command words in a small FIFO.
- Presents the head word on command_out, which connects to the conveyor's command_in.
- Honours conveyor_stop backpressure, redirects and flushes on jump_start, and injects bubbles (stamp bits 3'b111) whenever the queue is empty.

---
 rtl/fetch_queue.sv | 153 +++++++++++++++
 tb/tb_fetch_queue.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch stage feeding the conveyor.
//   Drives the fetch PC to instruction memory, buffers returned 88-bit command
//   words in a DEPTH-entry FIFO and presents the head word to the conveyor.
//   An empty queue (or a jump) presents BUBBLE = {85'b0, 3'b111}.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   imem_addr       registered fetch PC
//   imem_req        fetch request (combinational)
//   imem_ack        memory accepts request; imem_data valid this cycle
//   imem_data       returned command word
//   conveyor_stop   conveyor does not load command_out this cycle
//   jump_start      redirect to jump_target and flush the queue
//   jump_target     new fetch PC
//   command_out     head word or BUBBLE (combinational from storage)
//   level           FIFO occupancy, 0..DEPTH
//   starve_cnt      (FETCH_STARVE_CNT_EN only) saturating count of bubbles
//                   consumed by a running conveyor while starved
//
// Optional feature macro: FETCH_STARVE_CNT_EN

module fetch_queue #(
    parameter int unsigned             DEPTH    = 4,
    parameter int unsigned             ADDR_W   = 16,
    parameter logic [ADDR_W-1:0]       RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [ADDR_W-1:0]          imem_addr,
    output logic                       imem_req,
    input  logic                       imem_ack,
    input  logic [87:0]                imem_data,
    input  logic                       conveyor_stop,
    input  logic                       jump_start,
    input  logic [ADDR_W-1:0]          jump_target,
    output logic [87:0]                command_out,
    output logic [$clog2(DEPTH):0]     level
`ifdef FETCH_STARVE_CNT_EN
    ,
    output logic [15:0]                starve_cnt
`endif
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned LVL_W  = PTR_W + 1;
    localparam int unsigned WORD_W = 88;
    localparam logic [WORD_W-1:0] BUBBLE = {85'b0, 3'b111};

    logic [ADDR_W-1:0] r_pc;
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [LVL_W-1:0]  r_level;
    logic [WORD_W-1:0] r_mem [DEPTH];

    logic              w_full;
    logic              w_empty;
    logic              w_req;
    logic              w_push;
    logic              w_pop;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [PTR_W-1:0]  w_head_nxt;
    logic [PTR_W-1:0]  w_tail_nxt;
    logic [LVL_W-1:0]  w_level_nxt;

    // Handshake qualification: jump has priority and blocks both push and pop
    always_comb begin
        w_full  = (r_level == LVL_W'(DEPTH));
        w_empty = (r_level == '0);
        w_req   = !rst && !w_full && !jump_start;
        w_push  = w_req && imem_ack;
        w_pop   = !conveyor_stop && !w_empty && !jump_start;
    end

    // Next-state for PC, pointers and occupancy
    always_comb begin
        w_pc_nxt    = r_pc;
        w_head_nxt  = r_head;
        w_tail_nxt  = r_tail;
        w_level_nxt = r_level;
        if (jump_start) begin
            w_pc_nxt    = jump_target;
            w_head_nxt  = '0;
            w_tail_nxt  = '0;
            w_level_nxt = '0;
        end else begin
            if (w_push) begin
                w_tail_nxt = r_tail + PTR_W'(1);
                w_pc_nxt   = r_pc + ADDR_W'(1);
            end
            if (w_pop) begin
                w_head_nxt = r_head + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                w_level_nxt = r_level + LVL_W'(1);
            end else if (w_pop && !w_push) begin
                w_level_nxt = r_level - LVL_W'(1);
            end
        end
    end

    // Control state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc    <= RESET_PC;
            r_head  <= '0;
            r_tail  <= '0;
            r_level <= '0;
        end else begin
            r_pc    <= w_pc_nxt;
            r_head  <= w_head_nxt;
            r_tail  <= w_tail_nxt;
            r_level <= w_level_nxt;
        end
    end

    // Word storage; contents are qualified by level, so no reset is needed
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail] <= imem_data;
        end
    end

    // Head word goes straight to the conveyor with no added latency
    always_comb begin
        command_out = BUBBLE;
        if (!w_empty && !jump_start) begin
            command_out = r_mem[r_head];
        end
    end

    assign imem_addr = r_pc;
    assign imem_req  = w_req;
    assign level     = r_level;

`ifdef FETCH_STARVE_CNT_EN
    logic [15:0] r_starve_cnt;
    logic        w_starve;

    // Running conveyor with nothing to pop consumes a bubble
    assign w_starve = !conveyor_stop && w_empty && !jump_start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (w_starve && (r_starve_cnt != 16'hFFFF)) begin
            r_starve_cnt <= r_starve_cnt + 16'd1;
        end
    end

    assign starve_cnt = r_starve_cnt;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: fetched words are queued when a push is
// expected and compared against command_out when the conveyor pops them.
module tb_fetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam int unsigned ADDR_W   = 16;
    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam logic [87:0] BUBBLE   = {85'b0, 3'b111};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] imem_addr;
    logic        imem_req;
    logic        imem_ack = 1'b0;
    logic [87:0] imem_data;
    logic        conveyor_stop = 1'b0;
    logic        jump_start = 1'b0;
    logic [15:0] jump_target = 16'h0000;
    logic [87:0] command_out;
    logic [2:0]  level;
`ifdef FETCH_STARVE_CNT_EN
    logic [15:0] starve_cnt;
`endif

    int          n_vec = 0;
    int          n_err = 0;
    logic [87:0] sb [$];
    logic [15:0] m_pc;
    int          m_starve;

    always #5 clk = ~clk;

    // Address-tagged words; low stamp bits are 0 so they never look like BUBBLE
    function automatic logic [87:0] word_for(input logic [15:0] a);
        logic [15:0] m;
        m = 16'(a * 16'd7);
        return {a, ~a, m, 16'hC0DE, 8'h3C, a[12:0], 3'b000};
    endfunction

    // Instruction memory answers whatever address the DUT presents
    assign imem_data = word_for(imem_addr);

    fetch_queue #(
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_addr     (imem_addr),
        .imem_req      (imem_req),
        .imem_ack      (imem_ack),
        .imem_data     (imem_data),
        .conveyor_stop (conveyor_stop),
        .jump_start    (jump_start),
        .jump_target   (jump_target),
        .command_out   (command_out),
        .level         (level)
`ifdef FETCH_STARVE_CNT_EN
        ,
        .starve_cnt    (starve_cnt)
`endif
    );

    task automatic check_eq(input string tag, input logic [87:0] got, input logic [87:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs, advance the model
    task automatic step(input logic ack, input logic stop, input logic jmp, input logic [15:0] tgt);
        logic        exp_req;
        logic [87:0] exp_cmd;
        logic [87:0] popped;
        imem_ack      = ack;
        conveyor_stop = stop;
        jump_start    = jmp;
        jump_target   = tgt;
        #1;
        exp_req = (sb.size() < DEPTH) && !jmp;
        exp_cmd = (sb.size() != 0 && !jmp) ? sb[0] : BUBBLE;
        check_eq("level", 88'(level), 88'(sb.size()));
        check_eq("imem_addr", 88'(imem_addr), 88'(m_pc));
        check_eq("imem_req", 88'(imem_req), 88'(exp_req));
`ifdef FETCH_STARVE_CNT_EN
        check_eq("starve_cnt", 88'(starve_cnt), 88'(m_starve));
`endif
        if (jmp) begin
            check_eq("jump_bubble", command_out, BUBBLE);
            sb.delete();
            m_pc = tgt;
        end else begin
            if (!stop && sb.size() != 0) begin
                popped = sb.pop_front();
                check_eq("pop_word", command_out, popped);
            end else begin
                check_eq("cmd_out", command_out, exp_cmd);
                if (!stop && m_starve < 65535) m_starve++;
            end
            if (exp_req && ack) begin
                sb.push_back(word_for(m_pc));
                m_pc = m_pc + 16'd1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Asynchronous reset asserted between clock edges
    task automatic do_reset();
        imem_ack      = 1'b0;
        conveyor_stop = 1'b0;
        jump_start    = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_eq("rst_level", 88'(level), 88'(0));
        check_eq("rst_req", 88'(imem_req), 88'(0));
        check_eq("rst_cmd", command_out, BUBBLE);
        sb.delete();
        m_pc     = RESET_PC;
        m_starve = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rst_addr", 88'(imem_addr), 88'(RESET_PC));
    endtask

    initial begin
        do_reset();

        // Streaming: ack every cycle, no stall
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 16'h0);

        // Fill under stall until full, then single pop and refill
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 16'h0);
        step(1'b1, 1'b0, 1'b0, 16'h0);
        step(1'b1, 1'b1, 1'b0, 16'h0);
        step(1'b0, 1'b0, 1'b0, 16'h0);

        // Jump at level 3 with a coincident ack, then stream the new target
        step(1'b1, 1'b0, 1'b1, 16'h0040);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 16'h0);

        // Jump under stall still flushes
        step(1'b1, 1'b1, 1'b0, 16'h0);
        step(1'b1, 1'b1, 1'b1, 16'h0080);
        step(1'b1, 1'b0, 1'b0, 16'h0);

        // Starvation: no acks, conveyor running
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 16'h0);
        check_eq("starve_level", 88'(level), 88'(0));

        // PC wrap across 16'hFFFF
        step(1'b0, 1'b0, 1'b1, 16'hFFFE);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 16'h0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 16'h0);

        // Async reset mid-stream at level 2
        do_reset();
        step(1'b1, 1'b1, 1'b0, 16'h0);
        step(1'b1, 1'b1, 1'b0, 16'h0);
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 16'h0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 24) == 0, 16'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
